// File: rtl/dll_lock_detect_pkg.sv
// Shared constants for the DLL lock monitor: default sizing and FSM state encodings,
// kept in one place so the DLL controller and the monitor agree.
package dll_lock_detect_pkg;

  localparam int unsigned CntWDef = 8;
  localparam int unsigned TolDef  = 1;
  localparam int unsigned HystDef = 4;
  localparam int unsigned DivW    = 5;
  localparam int unsigned StreakW = 4;

  localparam logic [1:0] StDisabled = 2'd0;
  localparam logic [1:0] StArm      = 2'd1;
  localparam logic [1:0] StTrack    = 2'd2;

endpackage

// File: rtl/dll_lock_detect_if.sv
// Control/status bundle between the lock monitor and its user.
interface dll_lock_detect_if import dll_lock_detect_pkg::*; #(
  parameter int unsigned CNT_W = CntWDef
);
  logic            enable;
  logic            osc;
  logic [DivW-1:0] div;
  logic            locked;
  logic            lost;
  logic [CNT_W-1:0] count;
  logic            count_valid;

  modport master (
    output enable, osc, div,
    input  locked, lost, count, count_valid
  );

  modport slave (
    input  enable, osc, div,
    output locked, lost, count, count_valid
  );
endinterface

// File: rtl/dll_osc_sync.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous input entering
// the DLL clock domain.
module dll_osc_sync (
  input  logic clock,
  input  logic resetb,
  input  logic i_async,
  output logic o_rise
);
  logic [1:0] r_sync;
  logic       r_prev;

  always_ff @(posedge clock) begin
    if (!resetb) begin
      r_sync <= 2'b00;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_async};
      r_prev <= r_sync[1];
    end
  end

  assign o_rise = r_sync[1] & ~r_prev;
endmodule

// File: rtl/dll_lock_detect.sv
// DLL lock monitor: counts DLL clocks per osc period, compares against div and reports
// a debounced lock level, a loss-of-lock pulse and the raw measurement.
module dll_lock_detect import dll_lock_detect_pkg::*; #(
  parameter int unsigned CNT_W = CntWDef,
  parameter int unsigned TOL   = TolDef,
  parameter int unsigned HYST  = HystDef
) (
  input  logic              clock,
  input  logic              resetb,
  dll_lock_detect_if.slave  bus
);
  localparam logic [CNT_W-1:0]   CntMax = '1;
  localparam logic [CNT_W-1:0]   CntOne = CNT_W'(1);
  localparam logic [CNT_W:0]     TolV   = (CNT_W+1)'(TOL);
  localparam logic [StreakW-1:0] HystV  = StreakW'(HYST);

  logic [1:0]         r_state;
  logic [StreakW-1:0] r_streak;
  logic [CNT_W-1:0]   r_counter;
  logic [DivW-1:0]    r_div_q;
  logic               r_locked;
  logic               r_lost;
  logic [CNT_W-1:0]   r_count;
  logic               r_count_valid;

  logic               w_rise;
  logic [CNT_W:0]     w_diff;
  logic [CNT_W:0]     w_mag;
  logic               w_match;
  logic               w_div_chg;
  logic               w_sat;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [StreakW-1:0] w_streak_inc;

  dll_osc_sync u_osc_sync (
    .clock   (clock),
    .resetb  (resetb),
    .i_async (bus.osc),
    .o_rise  (w_rise)
  );

  always_comb begin
    // Diff spans -(2^DivW-1)..2^CNT_W-1, so the extra bit is a valid sign.
    w_diff       = {1'b0, r_counter} - (CNT_W+1)'(r_div_q);
    w_mag        = w_diff[CNT_W] ? -w_diff : w_diff;
    w_match      = (r_div_q != '0) && (w_mag <= TolV);
    w_div_chg    = (bus.div != r_div_q);
    w_sat        = (r_counter == CntMax);
    w_cnt_inc    = w_sat ? r_counter : r_counter + CntOne;
    w_streak_inc = (r_streak >= HystV) ? HystV : r_streak + StreakW'(1);
  end

  always_ff @(posedge clock) begin
    if (!resetb || !bus.enable) begin
      r_state       <= StDisabled;
      r_streak      <= '0;
      r_counter     <= '0;
      r_div_q       <= '0;
      r_locked      <= 1'b0;
      r_lost        <= 1'b0;
      r_count       <= '0;
      r_count_valid <= 1'b0;
    end else begin
      r_lost        <= 1'b0;
      r_count_valid <= 1'b0;
      if (r_state == StDisabled) begin
        r_state   <= StArm;
        r_div_q   <= bus.div;
        r_counter <= '0;
      end else if (r_state != StArm && r_state != StTrack) begin
        r_state <= StDisabled;
      end else if (w_div_chg) begin
        // A rise in this cycle is dropped; the new ratio needs a fresh partial period.
        r_div_q   <= bus.div;
        r_streak  <= '0;
        r_locked  <= 1'b0;
        r_lost    <= r_locked;
        r_state   <= StArm;
        r_counter <= w_cnt_inc;
      end else if (r_state == StArm) begin
        if (w_rise) begin
          r_counter <= CntOne;
          r_state   <= StTrack;
        end else begin
          r_counter <= w_cnt_inc;
        end
      end else if (w_rise) begin
        r_counter     <= CntOne;
        r_count       <= r_counter;
        r_count_valid <= 1'b1;
        if (w_match) begin
          r_streak <= w_streak_inc;
          r_locked <= (w_streak_inc >= HystV);
        end else begin
          r_streak <= '0;
          r_locked <= 1'b0;
          r_lost   <= r_locked;
        end
      end else if (w_sat) begin
        // Leaving TRACK makes the timeout a single event rather than a per-cycle one.
        r_streak <= '0;
        r_locked <= 1'b0;
        r_lost   <= r_locked;
        r_state  <= StArm;
      end else begin
        r_counter <= w_cnt_inc;
      end
    end
  end

  assign bus.locked      = r_locked;
  assign bus.lost        = r_lost;
  assign bus.count       = r_count;
  assign bus.count_valid = r_count_valid;
endmodule

// File: tb/tb_dll_lock_detect.sv
// Self-checking bench for dll_lock_detect: table rows, hand-written corner sequences and
// randomized osc periods checked against a period-level reference model.
module tb_dll_lock_detect;
  import dll_lock_detect_pkg::*;

  localparam int MaxCnt = 255;
  localparam int Tol    = 1;
  localparam int Hyst   = 4;

  logic clock = 1'b0;
  logic resetb;
  int   cyc = 0;

  dll_lock_detect_if #(.CNT_W(8)) bus ();

  dll_lock_detect #(.CNT_W(8), .TOL(1), .HYST(4)) dut (
    .clock  (clock),
    .resetb (resetb),
    .bus    (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int count;
    bit locked;
    bit lost;
  } ev_t;

  typedef struct {
    logic [4:0] div;
    int         period;
    int         n;
    int         exp_count;
    bit         exp_locked;
    int         exp_lost;
  } row_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  int  act_lost = 0;

  always @(negedge clock) begin
    if (bus.lost) act_lost++;
    if (bus.count_valid) obs_q.push_back(ev_t'{int'(bus.count), bus.locked, bus.lost});
  end

  int errors = 0;
  int checks = 0;
  int rd = 0;

  // Reference model: works on osc rise times only.
  int m_div;
  int m_streak = 0;
  bit m_locked = 1'b0;
  bit m_armed = 1'b1;
  int m_last = 0;
  int m_lost = 0;

  function automatic void model_rise(int t);
    int  p;
    bit  prev;
    bit  match;
    if (m_armed) begin
      m_armed = 1'b0;
      m_last  = t;
      return;
    end
    p      = t - m_last;
    m_last = t;
    if (p > MaxCnt) begin
      // Timed out earlier; this rise is the discarded partial one.
      if (m_locked) m_lost++;
      m_locked = 1'b0;
      m_streak = 0;
      return;
    end
    match    = (m_div != 0) && ((p > m_div ? p - m_div : m_div - p) <= Tol);
    prev     = m_locked;
    m_streak = match ? ((m_streak + 1 > Hyst) ? Hyst : m_streak + 1) : 0;
    m_locked = (m_streak >= Hyst);
    if (prev && !m_locked) m_lost++;
    exp_q.push_back(ev_t'{p, m_locked, prev && !m_locked});
  endfunction

  function automatic void model_div(int d);
    if (m_locked) m_lost++;
    m_locked = 1'b0;
    m_streak = 0;
    m_armed  = 1'b1;
    m_div    = d;
  endfunction

  function automatic void model_disable();
    m_locked = 1'b0;
    m_streak = 0;
    m_armed  = 1'b1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_period(input int p);
    bus.osc = 1'b1;
    model_rise(cyc);
    repeat (p / 2) tick();
    bus.osc = 1'b0;
    repeat (p - p / 2) tick();
  endtask

  task automatic idle(input int n);
    bus.osc = 1'b0;
    repeat (n) tick();
  endtask

  task automatic set_div(input int d);
    if (d != int'(bus.div)) begin
      bus.div = 5'(d);
      model_div(d);
      tick();
    end
  endtask

  task automatic drain();
    for (; rd < obs_q.size() && rd < exp_q.size(); rd++) begin
      check("cv_count", obs_q[rd].count, exp_q[rd].count);
      check("cv_locked", int'(obs_q[rd].locked), int'(exp_q[rd].locked));
      check("cv_lost", int'(obs_q[rd].lost), int'(exp_q[rd].lost));
    end
    check("cv_events", obs_q.size(), exp_q.size());
  endtask

  task automatic checkpoint();
    drain();
    check("locked", int'(bus.locked), int'(m_locked));
    check("lost_total", act_lost, m_lost);
  endtask

  task automatic check_cleared(input string name);
    check({name, "_locked"}, int'(bus.locked), 0);
    check({name, "_lost"}, int'(bus.lost), 0);
    check({name, "_count"}, int'(bus.count), 0);
    check({name, "_cv"}, int'(bus.count_valid), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    row_t rows[9];
    int   lost0;
    int   n0;
    int   divs[5];

    rows[0] = '{5'd8,  8,  4, 8,  1'b0, 0};
    rows[1] = '{5'd8,  8,  1, 8,  1'b1, 0};
    rows[2] = '{5'd8,  9,  3, 9,  1'b1, 0};
    rows[3] = '{5'd8,  10, 2, 10, 1'b0, 1};
    rows[4] = '{5'd8,  8,  4, 8,  1'b0, 0};
    rows[5] = '{5'd8,  7,  2, 7,  1'b1, 0};
    rows[6] = '{5'd0,  8,  6, 8,  1'b0, 1};
    rows[7] = '{5'd16, 16, 5, 16, 1'b1, 0};
    rows[8] = '{5'd8,  8,  5, 8,  1'b1, 1};
    divs    = '{0, 7, 8, 9, 12};

    resetb     = 1'b0;
    bus.enable = 1'b0;
    bus.osc    = 1'b0;
    bus.div    = 5'd8;
    m_div      = 8;
    repeat (3) tick();
    check_cleared("reset");
    resetb     = 1'b1;
    bus.enable = 1'b1;
    tick();

    foreach (rows[i]) begin
      lost0 = act_lost;
      set_div(int'(rows[i].div));
      repeat (rows[i].n) drive_period(rows[i].period);
      check($sformatf("row%0d_count", i), int'(bus.count), rows[i].exp_count);
      check($sformatf("row%0d_locked", i), int'(bus.locked), int'(rows[i].exp_locked));
      check($sformatf("row%0d_lost", i), act_lost - lost0, rows[i].exp_lost);
      checkpoint();
    end

    // osc stalls while locked: one lost pulse, no measurement.
    lost0 = act_lost;
    n0    = obs_q.size();
    idle(300);
    check("timeout_lost", act_lost - lost0, 1);
    check("timeout_no_cv", obs_q.size() - n0, 0);
    check("timeout_locked", int'(bus.locked), 0);
    check("timeout_count", int'(bus.count), 8);
    repeat (5) drive_period(8);
    check("timeout_relock", int'(bus.locked), 1);
    checkpoint();

    // One-cycle enable drop while locked: silent clear, then relock.
    bus.enable = 1'b0;
    tick();
    bus.enable = 1'b1;
    @(negedge clock);
    check_cleared("enable_low");
    model_disable();
    tick();
    repeat (5) drive_period(8);
    check("enable_relock", int'(bus.locked), 1);
    checkpoint();

    // Same for a reset pulse.
    resetb = 1'b0;
    tick();
    resetb = 1'b1;
    @(negedge clock);
    check_cleared("resetb_low");
    model_disable();
    tick();
    repeat (5) drive_period(8);
    check("reset_relock", int'(bus.locked), 1);
    checkpoint();

    for (int i = 0; i < 150; i++) begin
      int r;
      int p;
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        set_div(divs[$urandom_range(0, 4)]);
      end else if (r < 12) begin
        idle(260);
        drive_period(8);
      end else if (r < 75) begin
        p = (m_div == 0) ? 8 : m_div + int'($urandom_range(0, 2)) - 1;
        drive_period(p);
      end else begin
        drive_period(int'($urandom_range(5, 14)));
      end
    end
    checkpoint();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dll_lock_detect.md
Name: dll_lock_detect

Overview:
- Lock monitor placed directly downstream of the digital locked loop.
- Runs on the DLL output clock (clockp[0]) and measures how many DLL clock cycles fit in each period of the reference oscillator osc.
- Compares each measurement against the feedback division ratio div and reports a debounced lock indication.
- Provides a loss-of-lock pulse and the raw period measurement for housekeeping/status registers.

Parameters:
- CNT_W, 8, width of the period counter and the count output; saturates at 2^CNT_W-1.
- TOL, 1, allowed absolute difference between the measured period and div for a period to count as a match.
- HYST, 4, number of consecutive matching periods required to assert locked (range 1..15).

Ports:
- clock  input  1  DLL output clock (clockp[0]); the only clock.
- resetb  input  1  synchronous, active-low reset.
- enable  input  1  monitor enable; low acts as a synchronous clear.
- osc  input  1  reference oscillator, asynchronous to clock.
- div  input  5  expected DLL cycles per osc period; same value as given to the DLL.
- locked  output  1  lock status, level.
- lost  output  1  one-cycle pulse when locked falls 1->0 for any reason other than reset or enable low.
- count  output  CNT_W  last completed period measurement.
- count_valid  output  1  one-cycle pulse when count updates.

Behaviour:
- Clock and reset: one clock. Reset is synchronous, active-low, on resetb, and is sampled only on the rising edge of clock.
- Reset values: locked=0, lost=0, count=0, count_valid=0. Internal state is DISABLED, the streak is 0, and the counter is 0.
- enable=0: same effect as reset, one cycle later at most. Deasserting enable while locked gives no lost pulse.
- osc capture:
  - osc passes through a 2-flop synchronizer, then an edge register.
  - The rise pulse asserts in the third clock cycle after osc rises (±1 cycle of sampling uncertainty).
- Period counter:
  - On a rise cycle the counter is loaded with 1. Otherwise it increments, saturating at 2^CNT_W-1.
  - With osc edges exactly N clocks apart, the value captured at the next rise is N.
- FSM states:
  - DISABLED: when enable=1, go to ARM and register div into div_q.
  - ARM: wait for the first rise and discard it, since that period is partial. Load the counter and go to TRACK. locked stays 0.
  - TRACK, on each rise:
    - count <= counter value and count_valid=1 in the next cycle.
    - The period matches when div_q != 0 and |counter - div_q| <= TOL.
    - Match: streak increments, saturating at HYST. locked=1 in the same cycle as count_valid once the streak reaches HYST.
    - Mismatch: streak <= 0. If locked was 1, locked <= 0 and lost pulses together with count_valid.
- Timeout:
  - In TRACK, if the counter reaches saturation, treat it as an immediate mismatch: streak=0, locked=0, lost pulses if locked was 1.
  - FSM goes to ARM. count is not updated and count_valid is not asserted.
  - The pulse is issued once per saturation event, not every cycle.
- div change: if div != div_q in ARM or TRACK, then div_q <= div, streak=0, and the FSM goes to ARM. locked drops and lost pulses if locked was 1.
- div=0 is a valid input but never matches, so locked stays 0.
- Simultaneous events:
  - resetb low or enable low overrides everything.
  - A div change overrides a rise in the same cycle; that rise is discarded.
  - Saturation and a rise in the same cycle are handled as a rise with count = max value, which mismatches.
- Arithmetic: the comparison is done with unsigned CNT_W+1 bit subtraction. div_q is zero-extended. TOL is compared against the magnitude of the difference.

Decomposition:
- Shared include dll_defs.vh holds:
  - the FSM state encodings (DISABLED=2'd0, ARM=2'd1, TRACK=2'd2);
  - the default CNT_W, TOL and HYST constants, so the DLL controller and this block agree.
- One natural sub-module, dll_osc_sync: 2-flop synchronizer plus rising-edge detector, output rise. It is reusable for other asynchronous inputs into the DLL clock domain.

Test Plan:
- div=8, osc period = 8 clocks, enable=1 -> first rise discarded; count=8 on every count_valid; locked=1 at the 4th count_valid; lost never pulses.
- Locked at div=8, period steps to 9 clocks, then 10 clocks -> count=9 keeps locked=1; count=10 gives locked=0 with a single-cycle lost coincident with count_valid.
- Locked, osc held low -> counter saturates at 255 -> locked=0, exactly one lost pulse, no count_valid. osc restarts with an 8-clock period -> relock after first rise discarded plus 4 matches.
- Locked, div changes 8->16 with period 16 -> lost pulse, locked=0, ARM. Relock at the 4th count_valid with count=16.
- div=0, any osc period -> count updates but locked stays 0 indefinitely.
- Locked, enable=0 for 1 cycle (or resetb=0) -> all outputs 0 next cycle, no lost pulse. Re-enable -> DISABLED->ARM sequence repeats.
